// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared channel indices and channel FSM encoding for btn_input_ctl
//
// Contents:
//   NUM_BTN        number of button channels
//   BTN_L..BTN_U   bit positions of each button in btn_raw/btn_level/btn_press
//   btn_state_t    per-channel press/repeat FSM state
package btn_pkg;

    localparam int NUM_BTN = 4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DELAY      = 2'd1,
        ST_REPEAT     = 2'd2,
        ST_HELD_NOREP = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchronizer, debounce, press pulse, auto-repeat
//
// Ports:
//   pclk       pixel clock, rising edge
//   rst        asynchronous active-low reset
//   raw        raw button pin, asynchronous to pclk
//   repeat_en  1 = hold-to-repeat enabled for this channel
//   hold       1 = freeze repeat timer and suppress repeat pulses
//   level      debounced level, registered
//   press      one-cycle pulse per accepted press or repeat, registered
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 750000,
    parameter int REPEAT_DELAY    = 22500000,
    parameter int REPEAT_RATE     = 7500000,
    parameter int CNT_W           = 25
) (
    input  logic pclk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    input  logic hold,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rp_cnt;
    btn_state_t       state;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // db_cnt counts consecutive cycles where the synchronized input
    // disagrees with the accepted level; any agreeing cycle restarts it.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (s2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_ONE;
        end
    end

    // Press/repeat FSM works from the registered level, so the first pulse
    // lands one cycle after level rises. Release overrides every state.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            rp_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!level) begin
                state  <= ST_IDLE;
                rp_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        press  <= 1'b1;
                        rp_cnt <= '0;
                        state  <= repeat_en ? ST_DELAY : ST_HELD_NOREP;
                    end
                    ST_DELAY: begin
                        if (!hold) begin
                            if (rp_cnt == DELAY_LAST) begin
                                press  <= 1'b1;
                                rp_cnt <= '0;
                                state  <= ST_REPEAT;
                            end else begin
                                rp_cnt <= rp_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!hold) begin
                            if (rp_cnt == RATE_LAST) begin
                                press  <= 1'b1;
                                rp_cnt <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + CNT_ONE;
                            end
                        end
                    end
                    ST_HELD_NOREP: begin
                        state <= ST_HELD_NOREP;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_input_ctl.sv
// rtl/btn_input_ctl.sv - conditions the four board buttons into debounced levels and press pulses
//
// Ports:
//   pclk       pixel clock, rising edge
//   rst        asynchronous active-low reset
//   btn_raw    raw button pins {U,D,R,L}, asynchronous to pclk
//   btn_level  debounced levels {U,D,R,L}, registered
//   btn_press  one-cycle press/repeat pulses {U,D,R,L}, registered
module btn_input_ctl
    import btn_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 750000,
    parameter int         REPEAT_DELAY    = 22500000,
    parameter int         REPEAT_RATE     = 7500000,
    parameter logic [3:0] REPEAT_MASK     = 4'b0111,
    parameter int         CNT_W           = 25
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press
);

    // Left and right held together is contradictory movement: both channels
    // keep their repeat timers frozen until one side is let go.
    logic lr_hold;
    assign lr_hold = btn_level[BTN_L] & btn_level[BTN_R];

    for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
        localparam bit IS_LR = (ch == BTN_L) || (ch == BTN_R);

        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .CNT_W           (CNT_W)
        ) u_channel (
            .pclk      (pclk),
            .rst       (rst),
            .raw       (btn_raw[ch]),
            .repeat_en (REPEAT_MASK[ch]),
            .hold      (IS_LR ? lr_hold : 1'b0),
            .level     (btn_level[ch]),
            .press     (btn_press[ch])
        );
    end

endmodule

// File: tb/tb_btn_input_ctl.sv
// tb/tb_btn_input_ctl.sv - self-checking bench for btn_input_ctl
module tb_btn_input_ctl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam logic [3:0] MASK = 4'b0111;

    logic       pclk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;

    btn_input_ctl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .REPEAT_MASK     (MASK),
        .CNT_W           (25)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int vectors;
    int miscompares;
    int t;
    int q0[$];
    int q1[$];
    int q2[$];
    int q3[$];
    int want[$];

    // Reference model: raw sampled through two stages, level accepted after
    // DEB consecutive disagreeing samples, press pattern derived from the
    // hold age (edges since first press, not counting frozen L/R edges).
    logic [3:0] m_s1, m_s2, m_level, m_press;
    int         m_run[4];
    int         m_age[4];

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
        for (int c = 0; c < 4; c++) begin
            m_run[c] = 0;
            m_age[c] = -1;
        end
    endtask

    task automatic model_edge();
        logic [3:0] old_level;
        logic [3:0] mask_v;
        logic       lr;
        if (!rst) begin
            model_clear();
            return;
        end
        mask_v    = MASK;
        old_level = m_level;
        lr        = old_level[0] & old_level[1];
        for (int c = 0; c < 4; c++) begin
            m_press[c] = 1'b0;
            if (!old_level[c]) begin
                m_age[c] = -1;
            end else if (m_age[c] < 0) begin
                m_age[c]   = 0;
                m_press[c] = 1'b1;
            end else if (mask_v[c] && !(lr && c < 2)) begin
                m_age[c] = m_age[c] + 1;
                if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RR == 0))
                    m_press[c] = 1'b1;
            end
            if (m_s2[c] == old_level[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DEB) begin
                    m_level[c] = m_s2[c];
                    m_run[c]   = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, exp_v);
        end
    endtask

    function automatic string q_str(input int q[$]);
        string s;
        s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    task automatic chk_q(input string name, input int act[$], input int exp_q[$]);
        bit ok;
        vectors++;
        ok = (act.size() == exp_q.size());
        if (ok) foreach (act[i]) if (act[i] != exp_q[i]) ok = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s pulse edges actual=%s required=%s", name, q_str(act), q_str(exp_q));
        end
    endtask

    task automatic clear_q();
        t = 0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        t++;
        @(posedge pclk);
        model_edge();
        #1;
        chk("model_level", btn_level, m_level);
        chk("model_press", btn_press, m_press);
        if (btn_press[0]) q0.push_back(t);
        if (btn_press[1]) q1.push_back(t);
        if (btn_press[2]) q2.push_back(t);
        if (btn_press[3]) q3.push_back(t);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] prs;
    } vec_t;

    vec_t tbl[40];

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        rst         = 1'b0;
        btn_raw     = '0;
        model_clear();

        // Edge k counts from 1 = first edge after the raw value is applied.
        for (int i = 0; i < 20; i++) begin
            int k;
            k = i + 1;
            tbl[i].raw = (k <= 10) ? 4'b0001 : 4'b0000;
            tbl[i].lvl = (k >= 6 && k <= 15) ? 4'b0001 : 4'b0000;
            tbl[i].prs = (k == 7) ? 4'b0001 : 4'b0000;
        end
        for (int i = 20; i < 40; i++) begin
            int u;
            u = i - 19;
            tbl[i].raw = ((u >= 1 && u <= 3) || (u >= 7 && u <= 9)) ? 4'b0010 : 4'b0000;
            tbl[i].lvl = 4'b0000;
            tbl[i].prs = 4'b0000;
        end

        repeat (3) @(posedge pclk);
        #1;
        chk("reset_level", btn_level, 4'b0000);
        chk("reset_press", btn_press, 4'b0000);
        rst = 1'b1;

        // L press/release, then R glitches
        clear_q();
        for (int i = 0; i < 40; i++) begin
            step(tbl[i].raw);
            chk("tbl_level", btn_level, tbl[i].lvl);
            chk("tbl_press", btn_press, tbl[i].prs);
        end

        // D held 60 cycles: initial press then repeats
        clear_q();
        for (int k = 1; k <= 80; k++) step((k <= 60) ? 4'b0100 : 4'b0000);
        want = '{7, 27, 35, 43, 51, 59};
        chk_q("d_repeat", q2, want);

        // U held 60 cycles: never repeats
        clear_q();
        for (int k = 1; k <= 80; k++) step((k <= 60) ? 4'b1000 : 4'b0000);
        want = '{7};
        chk_q("u_norepeat", q3, want);

        // L then R five cycles later: repeats frozen while both held
        clear_q();
        for (int k = 1; k <= 100; k++) begin
            logic [3:0] r;
            r    = '0;
            r[0] = (k <= 80);
            r[1] = (k >= 6 && k <= 45);
            step(r);
        end
        want = '{7, 67, 75, 83};
        chk_q("lr_conflict_l", q0, want);
        want = '{12};
        chk_q("lr_conflict_r", q1, want);

        // Reset in the middle of an L hold
        clear_q();
        for (int k = 1; k <= 15; k++) step(4'b0001);
        want = '{7};
        chk_q("pre_reset_l", q0, want);
        rst = 1'b0;
        #1;
        chk("async_reset_level", btn_level, 4'b0000);
        chk("async_reset_press", btn_press, 4'b0000);
        step(4'b0001);
        step(4'b0001);
        rst = 1'b1;
        clear_q();
        for (int k = 1; k <= 10; k++) step(4'b0001);
        want = '{7};
        chk_q("post_reset_l", q0, want);
        for (int k = 1; k <= 20; k++) step(4'b0000);

        // Random bursts against the model, with occasional resets
        begin
            logic [3:0] r;
            r = '0;
            for (int k = 0; k < 3000; k++) begin
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(0, 9) == 0) r[c] = ~r[c];
                rst = ($urandom_range(0, 399) != 0);
                step(r);
            end
            rst = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_input_ctl.md
Name: btn_input_ctl

Overview:
- Conditions the four raw board buttons (L, R, D, U) before they reach the piece-movement controller (draw_rect_ctl).
- Per button, in this order: 2-flop synchronizer, debounce counter, single-cycle press pulse, optional hold-to-auto-repeat.
- Runs in the pixel clock domain (75 MHz pclk) so its pulses feed draw_rect_ctl directly.
- draw_rect_ctl consumes only btn_press; btn_level is for status/LEDs.

Parameters:
- DEBOUNCE_CYCLES, 750000: consecutive stable cycles needed to accept a new level (10 ms at 75 MHz).
- REPEAT_DELAY, 22500000: cycles from first pulse to first repeat pulse (300 ms).
- REPEAT_RATE, 7500000: cycles between subsequent repeat pulses (100 ms).
- REPEAT_MASK, 4'b0111: per-channel auto-repeat enable; bit0=L, 1=R, 2=D, 3=U. U (rotate) does not repeat.
- CNT_W, 25: counter width; must hold the largest of the three cycle counts.

Ports:
- pclk  input  1  pixel clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset. Polarity and asynchronous behaviour are fixed for this block.
- btn_raw  input  4  raw button pins {U,D,R,L}, asynchronous to pclk.
- btn_level  output  4  debounced level, registered.
- btn_press  output  4  one-pclk pulse per accepted press or repeat, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - Cleared: sync flops, debounce counters, repeat timers, btn_level, btn_press.
  - All channel FSMs go to IDLE.
  - Release is synchronous to pclk.
- Synchronizer: s1 <= btn_raw; s2 <= s1. Debounce logic uses s2 only.
- Debounce, per channel:
  - If s2 == btn_level, db_cnt <= 0.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1 and s2 still differs: btn_level <= s2 and db_cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES clears the count and never changes btn_level.
- Latency: a raw edge present before pclk edge 0 and held gives btn_level change after edge 2+DEBOUNCE_CYCLES. The btn_press pulse follows after edge 3+DEBOUNCE_CYCLES, high for exactly one cycle.
- Channel FSM (IDLE, DELAY, REPEAT), timer rp_cnt:
  - IDLE: on btn_level rise, pulse btn_press. Go to DELAY with rp_cnt <= 0 if the REPEAT_MASK bit is set; otherwise go to HELD_NOREP.
  - HELD_NOREP: a sub-state for non-repeating channels. Waits for btn_level low, then goes to IDLE. Emits no further pulses.
  - DELAY: rp_cnt increments. At rp_cnt == REPEAT_DELAY-1: pulse, rp_cnt <= 0, go to REPEAT.
  - REPEAT: rp_cnt increments. At rp_cnt == REPEAT_RATE-1: pulse, rp_cnt <= 0.
  - Any state: btn_level low forces IDLE and rp_cnt <= 0 on the same edge; no pulse is issued on release.
- L/R conflict: while btn_level[L] and btn_level[R] are both high, repeat pulses on both channels are suppressed and both rp_cnt are held.
  - Initial press pulses are not suppressed.
  - If both rise in the same cycle, both initial pulses are issued.
  - When one is released, the other resumes counting from its held rp_cnt.
- Channels are otherwise independent. Simultaneous presses on different channels each pulse in the same cycle.
- Reset mid-hold: after release from reset, a still-held button must re-debounce (btn_level restarts at 0). It then produces one fresh press pulse.
- Counters never wrap in normal operation. CNT_W is sized by parameter; parameter values exceeding 2^CNT_W are illegal.

Decomposition:
- Shared package/header btn_pkg:
  - Channel indices BTN_L=0, BTN_R=1, BTN_D=2, BTN_U=3.
  - FSM state encoding: IDLE, DELAY, REPEAT, HELD_NOREP (2 bits).
- Sub-module btn_channel: synchronizer + debounce + FSM for one bit.
  - Inputs: repeat_en, hold (L/R suppression).
  - Instantiated four times.
- Top btn_input_ctl: derives hold = btn_level[L] & btn_level[R] for channels L and R.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- Raw L high from cycle 0 for 10 cycles, then low -> btn_level[0] high after edge 6; one btn_press[0] pulse after edge 7; no pulse on release.
- Raw R glitch high for 3 cycles, low, then high again for 3 cycles -> btn_level[1] and btn_press[1] stay 0 throughout.
- Hold D for 60 cycles -> pulses at first-press cycle P, then P+20, P+28, P+36, P+44, P+52; stops within one cycle of btn_level falling.
- Hold U for 60 cycles -> exactly one btn_press[3] pulse.
- Press L, then R 5 cycles later, hold both 40 cycles -> one initial pulse each, no repeats while both held. Release R -> L repeats resume from its held count.
- Hold L 30 cycles, assert rst=0 mid-DELAY for 2 cycles, keep L held -> outputs 0 immediately; fresh btn_press[0] pulse 7 edges after reset release.
